// File: rtl/mssd_serializer.sv
// mssd_serializer: transmit end of the MSSD serial link.
// Frame on serOut, one bit per clock, MSB first:
//   start(0) | dest[0] dest[1] | len[3:0] | len data bytes | idle gap of GAP_CYCLES ones.
// A one-byte holding buffer with a valid/ready handshake feeds the data shift register.
// Optional build macro MSSD_TX_PARITY_EN appends an even-parity bit after every data byte.

module mssd_serializer #(
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frmValid,
   output logic       frmReady,
   input  logic [0:1] dest,
   input  logic [3:0] len,
   input  logic [7:0] dIn,
   input  logic       dInValid,
   output logic       dInReady,
   output logic       serOut,
   output logic       busy,
   output logic       done,
   output logic       error
);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StDest,
      StLen,
      StData,
      StGap
   } state_e;

   localparam logic [3:0] GapLast = 4'(GAP_CYCLES - 1);

`ifdef MSSD_TX_PARITY_EN
   // Bit index 8 of a byte slot is the parity cycle.
   localparam logic [3:0] DataLast = 4'd8;
`else
   localparam logic [3:0] DataLast = 4'd7;
`endif

   state_e     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;    // bit index in DEST/LEN/DATA, cycle index in GAP
   logic [3:0] byte_cnt_q, byte_cnt_d;  // bytes still to send, including the current one
   logic [0:1] dest_q, dest_d;
   logic [3:0] len_q, len_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] hold_q, hold_d;
   logic       hold_full_q, hold_full_d;
   logic       done_q, done_d;
   logic       error_q, error_d;
   logic       load_req;
`ifdef MSSD_TX_PARITY_EN
   logic       par_q, par_d;
`endif

   // State and datapath registers; asynchronous reset returns the line to idle at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         bit_cnt_q   <= 4'd0;
         byte_cnt_q  <= 4'd0;
         dest_q      <= 2'b00;
         len_q       <= 4'd0;
         shift_q     <= 8'd0;
         hold_q      <= 8'd0;
         hold_full_q <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
`ifdef MSSD_TX_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         dest_q      <= dest_d;
         len_q       <= len_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         done_q      <= done_d;
         error_q     <= error_d;
`ifdef MSSD_TX_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   // Next-state logic: frame sequencing, buffer capture and shift-register loads.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      dest_d      = dest_q;
      len_d       = len_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      done_d      = 1'b0;
      error_d     = 1'b0;
      load_req    = 1'b0;
`ifdef MSSD_TX_PARITY_EN
      par_d       = par_q;
`endif

      // Capture into the holding buffer; loads and flushes below override this.
      if (dInValid && !hold_full_q) begin
         hold_d      = dIn;
         hold_full_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (frmValid) begin
               dest_d     = dest;
               len_d      = len;
               byte_cnt_d = len;
               if (len == 4'd0) begin
                  error_d = 1'b1;
               end else begin
                  state_d = StStart;
               end
            end
         end
         StStart: begin
            state_d   = StDest;
            bit_cnt_d = 4'd0;
         end
         StDest: begin
            if (bit_cnt_q == 4'd1) begin
               state_d   = StLen;
               bit_cnt_d = 4'd0;
            end else begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         StLen: begin
            if (bit_cnt_q == 4'd3) begin
               load_req = 1'b1;
            end else begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         StData: begin
            shift_d = {shift_q[6:0], 1'b0};
            if (bit_cnt_q == DataLast) begin
               if (byte_cnt_q == 4'd1) begin
                  state_d   = StGap;
                  bit_cnt_d = 4'd0;
                  done_d    = 1'b1;
               end else begin
                  byte_cnt_d = byte_cnt_q - 4'd1;
                  load_req   = 1'b1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         StGap: begin
            if (bit_cnt_q == GapLast) begin
               state_d   = StIdle;
               bit_cnt_d = 4'd0;
            end else begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Load edge: take the buffered byte, or abort the frame on underrun.
      if (load_req) begin
         bit_cnt_d = 4'd0;
         if (hold_full_q) begin
            state_d     = StData;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
`ifdef MSSD_TX_PARITY_EN
            par_d       = ^hold_q;
`endif
         end else begin
            state_d     = StGap;
            error_d     = 1'b1;
            hold_full_d = 1'b0;
         end
      end
   end

   // Output decode from the current state.
   always_comb begin
      busy     = (state_q != StIdle);
      frmReady = (state_q == StIdle);
      dInReady = ~hold_full_q;
      done     = done_q;
      error    = error_q;
      serOut   = 1'b1;
      unique case (state_q)
         StStart: serOut = 1'b0;
         StDest:  serOut = dest_q[bit_cnt_q[0]];
         StLen:   serOut = len_q[2'd3 - bit_cnt_q[1:0]];
`ifdef MSSD_TX_PARITY_EN
         StData:  serOut = (bit_cnt_q == DataLast) ? par_q : shift_q[7];
`else
         StData:  serOut = shift_q[7];
`endif
         default: serOut = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_mssd_serializer.sv
// Self-checking bench for mssd_serializer: directed test-plan frames plus random frames,
// compared cycle by cycle against a bit-list model of the frame built from dest/len/bytes.

module tb_mssd_serializer;

   localparam int unsigned Gap = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       frmValid;
   logic       frmReady;
   logic [0:1] dest;
   logic [3:0] len;
   logic [7:0] dIn;
   logic       dInValid;
   logic       dInReady;
   logic       serOut;
   logic       busy;
   logic       done;
   logic       error;

   int checks = 0;
   int errors = 0;

   logic [7:0] frame_bytes [16];

   mssd_serializer #(
      .GAP_CYCLES(Gap)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .frmValid (frmValid),
      .frmReady (frmReady),
      .dest     (dest),
      .len      (len),
      .dIn      (dIn),
      .dInValid (dInValid),
      .dInReady (dInReady),
      .serOut   (serOut),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_serOut"}, serOut, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_frmReady"}, frmReady, 1);
      check({tag, "_dInReady"}, dInReady, 1);
      check({tag, "_done"}, done, 0);
      check({tag, "_error"}, error, 0);
   endtask

   // Sends a frame of n bytes from frame_bytes, of which only k are ever supplied.
   // Byte 0 is preloaded; later bytes are offered as soon as dInReady is seen high.
   task automatic run_frame(input logic [0:1] d, input logic [3:0] n, input int k);
      logic exp_bits [$];
      int   total;
      int   sent;
      logic uf;
      exp_bits = {};
      exp_bits.push_back(1'b0);
      exp_bits.push_back(d[0]);
      exp_bits.push_back(d[1]);
      for (int i = 3; i >= 0; i--) exp_bits.push_back(n[i]);
      for (int b = 0; b < k && b < int'(n); b++) begin
         for (int i = 7; i >= 0; i--) exp_bits.push_back(frame_bytes[b][i]);
`ifdef MSSD_TX_PARITY_EN
         exp_bits.push_back(^frame_bytes[b]);
`endif
      end
      uf    = (k < int'(n));
      total = exp_bits.size();
      sent  = 0;

      check("pre_dInReady", dInReady, 1);
      if (k > 0) begin
         dIn      = frame_bytes[0];
         dInValid = 1'b1;
         step;
         dInValid = 1'b0;
         sent     = 1;
         check("preload_dInReady", dInReady, 0);
      end
      check("pre_frmReady", frmReady, 1);
      dest     = d;
      len      = n;
      frmValid = 1'b1;
      step;
      frmValid = 1'b0;

      for (int c = 1; c <= total + int'(Gap) + 1; c++) begin
         if (sent < k && dInReady) begin
            dIn      = frame_bytes[sent];
            dInValid = 1'b1;
            sent++;
         end else begin
            dInValid = 1'b0;
         end
         if (c <= total) begin
            check($sformatf("bit%0d_serOut", c), serOut, exp_bits[c-1]);
            check($sformatf("bit%0d_busy", c), busy, 1);
            check($sformatf("bit%0d_frmReady", c), frmReady, 0);
            check($sformatf("bit%0d_done", c), done, 0);
            check($sformatf("bit%0d_error", c), error, 0);
         end else if (c <= total + int'(Gap)) begin
            check($sformatf("gap%0d_serOut", c), serOut, 1);
            check($sformatf("gap%0d_busy", c), busy, 1);
            check($sformatf("gap%0d_frmReady", c), frmReady, 0);
            check($sformatf("gap%0d_done", c), done, 32'(!uf && c == total + 1));
            check($sformatf("gap%0d_error", c), error, 32'(uf && c == total + 1));
         end else begin
            check_idle_outputs("after_frame");
         end
         step;
      end
      dInValid = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      frmValid = 1'b0;
      dest     = 2'b00;
      len      = 4'd0;
      dIn      = 8'd0;
      dInValid = 1'b0;
      #1;
      check_idle_outputs("in_reset");
      step;
      step;
      reset = 1'b0;
      step;
      check_idle_outputs("after_reset");

      // Basic frame: A5 to dest 10.
      frame_bytes[0] = 8'hA5;
      run_frame(2'b10, 4'd1, 1);

      // Multi-byte frame.
      frame_bytes[0] = 8'h00;
      frame_bytes[1] = 8'hFF;
      frame_bytes[2] = 8'h3C;
      run_frame(2'b01, 4'd3, 3);

      // Illegal length: error pulse only, nothing sent.
      len      = 4'd0;
      dest     = 2'b11;
      frmValid = 1'b1;
      step;
      frmValid = 1'b0;
      check("len0_error", error, 1);
      check("len0_serOut", serOut, 1);
      check("len0_busy", busy, 0);
      check("len0_frmReady", frmReady, 1);
      check("len0_done", done, 0);
      step;
      check("len0_error_clear", error, 0);
      check("len0_busy_after", busy, 0);
      check("len0_serOut_after", serOut, 1);

      // Underrun: second byte never arrives.
      frame_bytes[0] = 8'h5A;
      frame_bytes[1] = 8'h00;
      run_frame(2'b11, 4'd2, 1);

      // Underrun at the very first load (nothing preloaded).
      run_frame(2'b00, 4'd4, 0);

      // Single 07 byte (parity 1 when parity is built in).
      frame_bytes[0] = 8'h07;
      run_frame(2'b00, 4'd1, 1);

      // Reset during the 4th data bit, with a second byte waiting in the buffer.
      dIn      = 8'hC3;
      dInValid = 1'b1;
      step;
      dInValid = 1'b0;
      dest     = 2'b01;
      len      = 4'd2;
      frmValid = 1'b1;
      step;
      frmValid = 1'b0;
      for (int c = 1; c < 11; c++) begin
         if (c == 8) begin
            check("mid_dInReady_after_load", dInReady, 1);
            dIn      = 8'h81;
            dInValid = 1'b1;
         end else begin
            dInValid = 1'b0;
         end
         step;
      end
      check("mid_busy_before_reset", busy, 1);
      reset = 1'b1;
      #1;
      check_idle_outputs("mid_reset");
      step;
      reset = 1'b0;
      step;
      check_idle_outputs("post_mid_reset");
      frame_bytes[0] = 8'h96;
      run_frame(2'b10, 4'd1, 1);

      // Random frames, some with underrun.
      for (int f = 0; f < 12; f++) begin
         logic [0:1] rd;
         logic [3:0] rn;
         int         rk;
         rd = 2'($urandom);
         rn = 4'($urandom_range(15, 1));
         for (int b = 0; b < 16; b++) frame_bytes[b] = 8'($urandom);
         if ($urandom_range(3, 0) == 0) rk = int'($urandom_range(int'(rn) - 1, 0));
         else rk = int'(rn);
         run_frame(rd, rn, rk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mssd_serializer.md
Name: mssd_serializer

Overview:
- Transmit end of the multi-channel synchronous serial link. Builds the frame that the MSSD demultiplexer consumes: start bit, 2-bit destination, 4-bit byte count, then data bytes.
- Sits between a host byte source and the serial line. Has a frame-request handshake and a one-byte holding buffer with a valid/ready handshake.
- Sends one bit per clock, MSB first.

Parameters:
- GAP_CYCLES, 1: minimum idle-high cycles on serOut after each frame or abort (range 1..15).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- frmValid  input  1  host requests a frame; dest and len are valid.
- frmReady  output  1  block can accept a frame request.
- dest  input  [0:1]  destination port; dest[0] is sent first.
- len  input  4  number of data bytes, 1..15; 0 is illegal.
- dIn  input  8  data byte.
- dInValid  input  1  dIn is valid.
- dInReady  output  1  holding buffer is empty.
- serOut  output  1  serial line; idles at 1.
- busy  output  1  frame in progress, including the gap.
- done  output  1  one-cycle pulse when a frame completes.
- error  output  1  one-cycle pulse on illegal len or data underrun.

Behaviour:
- Reset (asynchronous):
  - serOut=1; frmReady=1; dInReady=1; busy=0; done=0; error=0.
  - Holding buffer empty, counters zero, FSM in IDLE.
  - Mid-frame reset drops serOut to 1 immediately; no done or error pulse.
- FSM states: IDLE, START, DEST, LEN, DATA, GAP.
- IDLE:
  - frmReady=1, serOut=1, busy=0.
  - On frmValid&frmReady: latch dest and len.
  - len!=0: go to START.
  - len==0: pulse error next cycle, stay IDLE, nothing transmitted.
- START: serOut=0 for 1 cycle.
- DEST: 2 cycles; serOut=dest[0], then dest[1].
- LEN: 4 cycles; serOut=len[3]..len[0].
- DATA: 8 cycles per byte, shift register MSB first. A byte counter counts down from len.
- Shift-register load: happens on the clock edge ending the last LEN bit, and on the edge ending bit 0 of each non-final byte.
  - Buffer full: move buffer into shift register; buffer becomes empty.
  - Buffer empty (underrun): abort. serOut=1 from the next cycle, error pulses 1 cycle, buffer is flushed, go to GAP. done is not pulsed.
- Final byte: after its bit 0, go to GAP. done pulses during the first GAP cycle.
- GAP: serOut=1 for GAP_CYCLES cycles, busy=1, frmReady=0, then IDLE.
- busy=1 and frmReady=0 from the cycle after acceptance through the end of GAP. No request is accepted while busy.
- Holding buffer:
  - dInReady = buffer empty (registered flag, no combinational path from dInValid).
  - A byte is captured on dInValid&dInReady.
  - Preloading is allowed in IDLE and during any state. At most one byte is held.
  - A byte left in the buffer after a frame is kept for the next frame.
  - At a load edge the buffer empties; dInReady rises the next cycle. There is no same-edge refill.
- Frame length on the wire: 7+8*len cycles, start bit through last data bit.
- Frame back-to-back spacing: minimum 7+8*len+GAP_CYCLES+1 cycles from accept to accept.
- Simultaneous events: reset overrides everything. Underrun takes precedence over done.

Optional Feature:
- Macro: MSSD_TX_PARITY_EN.
- Defined:
  - After bit 0 of every data byte, one extra cycle drives even parity (XOR of the 8 bits).
  - Frame length becomes 7+9*len.
  - The load/underrun check moves to the edge ending the parity bit.
- Undefined: no parity bit; frame length 7+8*len.

Test Plan:
- Basic frame: preload 8'hA5; request dest=2'b10, len=1.
  - serOut from cycle after accept: 0 | 1 0 | 0 0 0 1 | 1 0 1 0 0 1 0 1, then 1.
  - done pulses in cycle 16; busy falls after GAP.
- Multi-byte frame: len=3, bytes 8'h00, 8'hFF, 8'h3C, each supplied as soon as dInReady rises.
  - 31 frame bits, data 00000000 11111111 00111100.
  - No error; exactly one done.
- Illegal length: request len=0.
  - error pulses 1 cycle, serOut stays 1, busy stays 0, no done.
- Underrun: len=2; supply only the first byte.
  - After its 8 data bits serOut=1, error pulses 1 cycle, no done.
  - FSM returns to IDLE after GAP_CYCLES.
- Reset mid-frame: assert reset during the 4th data bit.
  - serOut=1 immediately, all outputs at reset values.
  - A new len=1 frame afterwards transmits correctly.
- Parity (MSSD_TX_PARITY_EN defined): len=1, byte 8'h07.
  - Data bits 00000111 followed by parity 1.
  - Frame is 16 bits; done pulses in cycle 17.
